// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a two-entry skid-buffer pipeline register with valid/ready
// handshakes on both sides and a synchronous flush.
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall_cnt and
// bubble_cnt performance counters.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous active-high reset; takes priority over flush
//   flush      - synchronous kill; empties the stage and drops any same-cycle input
//   in_valid   - upstream payload valid
//   in_ready   - stage can accept this cycle (EMPTY or FULL)
//   in_data    - upstream payload, DATA_W bits
//   out_valid  - downstream payload valid (FULL or SKID)
//   out_ready  - downstream accepts this cycle
//   out_data   - downstream payload, always driven by the main register
//   stall_cnt  - (PIPE_STAGE_PERF_EN) saturating count of out_valid & !out_ready cycles
//   bubble_cnt - (PIPE_STAGE_PERF_EN) saturating count of !out_valid & out_ready cycles
module pipe_stage_reg #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [DATA_W-1:0]   w_main_nxt;
  logic [DATA_W-1:0]   w_skid_nxt;
  logic                w_accept;
  logic                w_xfer;

  // Handshake outputs come from state only, so no input reaches an output combinationally.
  assign in_ready  = (r_state != S_SKID);
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Flush wins over any accept; a same-cycle transfer has already been seen downstream.
      w_state_nxt = S_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        w_main_nxt = '0;
        w_skid_nxt = '0;
      end
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_FULL;
            w_main_nxt  = in_data;
          end
        end
        S_FULL: begin
          if (w_accept && w_xfer) begin
            w_main_nxt = in_data;
          end else if (w_xfer) begin
            w_state_nxt = S_EMPTY;
          end else if (w_accept) begin
            w_state_nxt = S_SKID;
            w_skid_nxt  = in_data;
          end
        end
        S_SKID: begin
          if (w_xfer) begin
            w_state_nxt = S_FULL;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // Counters observe the handshake only; flush does not touch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!out_valid && out_ready && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready_c, out_valid_c;
  logic [DW-1:0] out_data_c;
  logic          in_ready_h, out_valid_h;
  logic [DW-1:0] out_data_h;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_c, bubble_c, stall_h, bubble_h;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_c),
    .in_data   (in_data),
    .out_valid (out_valid_c),
    .out_ready (out_ready),
    .out_data  (out_data_c)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_c),
    .bubble_cnt(bubble_c)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(0)) dut_hold (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_h),
    .in_data   (in_data),
    .out_valid (out_valid_h),
    .out_ready (out_ready),
    .out_data  (out_data_h)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_h),
    .bubble_cnt(bubble_h)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00A5;
    out_ready = 1'b0;

    // Reset with input activity present.
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid_c}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready_c},  32'd1);
    check("rst_out_data",  {16'd0, out_data_c},  32'd0);
    check("rst_hold_data", {16'd0, out_data_h},  32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall",  stall_c,  32'd0);
    check("rst_bubble", bubble_c, 32'd0);
`endif
    rst = 1'b0;

    // Streaming: 1,2,3 at full rate.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = DW'(i);
      tick();
      check("stream_valid", {31'd0, out_valid_c}, 32'd1);
      check("stream_data",  {16'd0, out_data_c},  32'(i));
      check("stream_ready", {31'd0, in_ready_c},  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'd0, out_valid_c}, 32'd0);

    // Backpressure into SKID.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0010;
    tick();
    check("bp_full_data",  {16'd0, out_data_c}, 32'h10);
    check("bp_full_ready", {31'd0, in_ready_c}, 32'd1);
    in_data = 16'h0011;
    tick();
    check("bp_skid_data",  {16'd0, out_data_c}, 32'h10);
    check("bp_skid_ready", {31'd0, in_ready_c}, 32'd0);
    in_data = 16'h0012;
    tick();
    check("bp_hold_data",  {16'd0, out_data_c}, 32'h10);
    check("bp_hold_ready", {31'd0, in_ready_c}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("bp_stall_cnt", stall_c, 32'd2);
`endif
    out_ready = 1'b1;
    tick();
    check("bp_out_11",   {16'd0, out_data_c}, 32'h11);
    check("bp_ready_rel", {31'd0, in_ready_c}, 32'd1);
    tick();
    check("bp_out_12",   {16'd0, out_data_c}, 32'h12);
    check("bp_valid_12", {31'd0, out_valid_c}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", {31'd0, out_valid_c}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("bp_stall_final", stall_c,  32'd2);
    check("bp_bubble",      bubble_c, 32'd1);
`endif

    // Flush from SKID with a competing input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0010;
    tick();
    in_data = 16'h0011;
    tick();
    check("fl_pre_skid", {31'd0, in_ready_c}, 32'd0);
    flush   = 1'b1;
    in_data = 16'h0099;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid",   {31'd0, out_valid_c}, 32'd0);
    check("fl_in_ready",    {31'd0, in_ready_c},  32'd1);
    check("fl_clear_data",  {16'd0, out_data_c},  32'd0);
    check("fl_hold_valid",  {31'd0, out_valid_h}, 32'd0);
    check("fl_hold_data",   {16'd0, out_data_h},  32'h10);
    out_ready = 1'b1;
    tick();
    check("fl_no_99_valid", {31'd0, out_valid_c}, 32'd0);
    check("fl_no_99_data",  {16'd0, out_data_c},  32'd0);

    // Flush from FULL with accept: input dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0020;
    tick();
    flush   = 1'b1;
    in_data = 16'h0099;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flf_valid", {31'd0, out_valid_c}, 32'd0);
    check("flf_hold",  {16'd0, out_data_h},  32'h20);

    // Reset beats flush while FULL.
    in_valid = 1'b1;
    in_data  = 16'h0030;
    tick();
    in_valid = 1'b0;
    check("rp_full_data", {16'd0, out_data_c}, 32'h30);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check("rp_valid",     {31'd0, out_valid_c}, 32'd0);
    check("rp_ready",     {31'd0, in_ready_c},  32'd1);
    check("rp_data",      {16'd0, out_data_c},  32'd0);
    check("rp_hold_valid", {31'd0, out_valid_h}, 32'd0);
    check("rp_hold_data", {16'd0, out_data_h},  32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0040;
    tick();
    in_valid = 1'b0;
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_stall", stall_c, 32'hFFFF_FFFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
